ram_readout: RTL



---
 rtl/ram_readout.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ram_readout.sv
// ---------------------------------------------------------------------------
// ram_readout
//
// Reads a block of on-chip RAM back word by word and unpacks each word into
// burst_index samples of sample_w bits. The samples are streamed out over a
// valid/ready handshake, oldest (slice 0, lowest bits) first.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       single-cycle request to begin a readout (ignored while busy)
//   ram_addr    registered read address to the RAM; doubles as the word counter
//   ram_q       read data from the RAM, burst_index samples packed per word
//   dout        current sample (slice 0 of the unpack buffer)
//   dout_valid  dout holds a valid sample
//   dout_ready  downstream accepts dout; a transfer is dout_valid & dout_ready
//   busy        a readout is in progress
//   done        level, high once the last sample has been accepted
// ---------------------------------------------------------------------------
module ram_readout #(
  parameter int no_of_digits    = 10,
  parameter int radix_bits      = 3,
  parameter int address_width   = 14,
  parameter int max_ram_address = 4096,
  parameter int burst_index     = 5,
  parameter int ram_latency     = 2,
  localparam int sample_w       = (no_of_digits + 1) * radix_bits
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  output logic [address_width-1:0]        ram_addr,
  input  logic [sample_w*burst_index-1:0] ram_q,
  output logic [sample_w-1:0]             dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            busy,
  output logic                            done
);

  localparam int slice_w = (burst_index > 1) ? $clog2(burst_index) : 1;
  localparam int wait_w  = (ram_latency > 1) ? $clog2(ram_latency) : 1;

  localparam logic [slice_w-1:0]       last_slice = slice_w'(burst_index - 1);
  localparam logic [address_width-1:0] last_addr  = address_width'(max_ram_address - 1);
  localparam logic [wait_w-1:0]        wait_load  = wait_w'(ram_latency - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, EMIT, DONE} state_t;

  state_t                            state, state_next;
  logic [slice_w-1:0]                slice_cnt;
  logic [wait_w-1:0]                 wait_cnt;
  logic [sample_w*burst_index-1:0]   unpack_buf;
  logic                              xfer;
  logic                              last_xfer;

  // Status outputs are pure decodes of the state, so they change together
  // with it and reset with it.
  assign dout       = unpack_buf[sample_w-1:0];
  assign dout_valid = (state == EMIT);
  assign busy       = (state == ADDR) || (state == WAIT) || (state == EMIT);
  assign done       = (state == DONE);

  assign xfer      = dout_valid && dout_ready;
  assign last_xfer = xfer && (slice_cnt == last_slice);

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = ADDR;
      ADDR:       state_next = WAIT;
      WAIT:       if (wait_cnt == '0) state_next = EMIT;
      EMIT: begin
        if (last_xfer) state_next = (ram_addr == last_addr) ? DONE : ADDR;
      end
      default:    state_next = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // ram_addr is the address counter itself: it is loaded/incremented on the
  // edge that enters ADDR, so it is stable through ADDR and WAIT and can never
  // leave 0..max_ram_address-1 (it only increments below last_addr).
  // NOTE: the unpack buffer is an ordinary register bank (not a RAM macro),
  // so it is cleared by reset like the rest of the state and dout reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr   <= '0;
      slice_cnt  <= '0;
      wait_cnt   <= '0;
      unpack_buf <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ram_addr  <= '0;
            slice_cnt <= '0;
          end
        end
        ADDR: wait_cnt <= wait_load;
        WAIT: begin
          // Capture on the final count of the latency window.
          if (wait_cnt == '0) begin
            unpack_buf <= ram_q;
            slice_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt - wait_w'(1);
          end
        end
        EMIT: begin
          if (xfer) begin
            unpack_buf <= unpack_buf >> sample_w;
            slice_cnt  <= (slice_cnt == last_slice) ? '0 : slice_cnt + slice_w'(1);
            if (last_xfer && (ram_addr != last_addr))
              ram_addr <= ram_addr + address_width'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
